// File: rtl/wb_pkg.sv
// Shared writeback-arbiter types: source ids, default widths and the queued result entry.
package wb_pkg;

  localparam int unsigned WORD_SIZE     = 32;
  localparam int unsigned INSTR_TYPE_SZ = 4;
  localparam int unsigned ROB_ID_SZ     = 7;
  localparam int unsigned NUM_SRC       = 3;

  localparam logic [1:0] SRC_ALU = 2'd0;
  localparam logic [1:0] SRC_MEM = 2'd1;
  localparam logic [1:0] SRC_MUL = 2'd2;

  typedef struct packed {
    logic [INSTR_TYPE_SZ-1:0] itype;
    logic [WORD_SIZE-1:0]     pc;
    logic [WORD_SIZE-1:0]     result;
    logic [ROB_ID_SZ-1:0]     rob_id;
  } wb_entry_t;

  // Round-robin successor of a source id (mod NUM_SRC).
  function automatic logic [1:0] rr_next(input logic [1:0] src);
    return (src == SRC_MUL) ? SRC_ALU : src + 2'd1;
  endfunction

endpackage

// File: rtl/wb_src_fifo.sv
// Per-source result FIFO; a push is accepted when not full or when the head pops on the same edge.
module wb_src_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [W-1:0]             i_data,
  output logic [W-1:0]             o_head,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !i_flush && (!o_full || i_pop);
  assign w_do_pop  = i_pop && !o_empty && !i_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: three per-source FIFOs merged round-robin onto one registered ROB write port.
module wb_arbiter #(
  parameter int unsigned WORD_SIZE     = wb_pkg::WORD_SIZE,
  parameter int unsigned INSTR_TYPE_SZ = wb_pkg::INSTR_TYPE_SZ,
  parameter int unsigned ROB_ID_SZ     = wb_pkg::ROB_ID_SZ,
  parameter int unsigned DEPTH         = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [2:0]                 src_valid,
  input  logic [3*INSTR_TYPE_SZ-1:0] src_type,
  input  logic [3*WORD_SIZE-1:0]     src_pc,
  input  logic [3*WORD_SIZE-1:0]     src_result,
  input  logic [3*ROB_ID_SZ-1:0]     src_rob_id,
  output logic [2:0]                 src_full,
  output logic                       rob_wr_en,
  output logic [ROB_ID_SZ-1:0]       rob_wr_id,
  output logic [INSTR_TYPE_SZ-1:0]   rob_wr_type,
  output logic [WORD_SIZE-1:0]       rob_wr_pc,
  output logic [WORD_SIZE-1:0]       rob_wr_value,
  output logic [1:0]                 rob_wr_src,
  output logic                       overflow_err
);

  import wb_pkg::wb_entry_t;
  import wb_pkg::NUM_SRC;
  import wb_pkg::rr_next;

  localparam int unsigned ENTRY_W = $bits(wb_entry_t);
  localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;

  wb_entry_t          w_push_entry [NUM_SRC];
  wb_entry_t          w_head       [NUM_SRC];
  logic [CNT_W-1:0]   w_count      [NUM_SRC];
  logic [NUM_SRC-1:0] w_empty;
  logic [NUM_SRC-1:0] w_pop;
  logic [NUM_SRC-1:0] w_drop;
  logic               w_grant_valid;
  logic [1:0]         w_grant_id;
  logic [2:0]         w_scan;
  wb_entry_t          w_win;

  logic [1:0]         r_rr_ptr;
  logic               r_overflow;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    assign w_push_entry[g] = {src_type[g*INSTR_TYPE_SZ +: INSTR_TYPE_SZ],
                              src_pc[g*WORD_SIZE +: WORD_SIZE],
                              src_result[g*WORD_SIZE +: WORD_SIZE],
                              src_rob_id[g*ROB_ID_SZ +: ROB_ID_SZ]};
    assign w_pop[g]  = w_grant_valid && (w_grant_id == 2'(g)) && !flush;
    assign w_drop[g] = src_valid[g] && !flush && !w_pop[g] && (w_count[g] == CNT_W'(DEPTH));

    wb_src_fifo #(
      .DEPTH (DEPTH),
      .W     (ENTRY_W)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (reset),
      .i_push  (src_valid[g]),
      .i_pop   (w_pop[g]),
      .i_flush (flush),
      .i_data  (w_push_entry[g]),
      .o_head  (w_head[g]),
      .o_empty (w_empty[g]),
      .o_full  (src_full[g]),
      .o_count (w_count[g])
    );
  end

  // First non-empty FIFO scanning from r_rr_ptr, wrapping mod NUM_SRC.
  always_comb begin
    w_grant_valid = 1'b0;
    w_grant_id    = r_rr_ptr;
    w_scan        = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      w_scan = {1'b0, r_rr_ptr} + 3'(k);
      if (w_scan >= 3'(NUM_SRC)) w_scan = w_scan - 3'(NUM_SRC);
      if (!w_grant_valid && !w_empty[w_scan[1:0]]) begin
        w_grant_valid = 1'b1;
        w_grant_id    = w_scan[1:0];
      end
    end
  end

  always_comb begin
    w_win = w_head[w_grant_id];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rr_ptr     <= '0;
      r_overflow   <= 1'b0;
      rob_wr_en    <= 1'b0;
      rob_wr_id    <= '0;
      rob_wr_type  <= '0;
      rob_wr_pc    <= '0;
      rob_wr_value <= '0;
      rob_wr_src   <= '0;
    end else begin
      if (|w_drop) r_overflow <= 1'b1;
      if (flush) begin
        rob_wr_en <= 1'b0;
      end else if (w_grant_valid) begin
        rob_wr_en    <= 1'b1;
        rob_wr_id    <= w_win.rob_id;
        rob_wr_type  <= w_win.itype;
        rob_wr_pc    <= w_win.pc;
        rob_wr_value <= w_win.result;
        rob_wr_src   <= w_grant_id;
        r_rr_ptr     <= rr_next(w_grant_id);
      end else begin
        rob_wr_en <= 1'b0;
      end
    end
  end

  assign overflow_err = r_overflow;

endmodule
